serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial N-bit adder controller that sequences one full-adder cell, built from two `ha` half-adder cells, across the operand bits one bit per clock. It accepts a start/operand handshake, shifts operands LSB-first through the shared cell with a registered carry, and presents the registered sum and carry-out with a one-cycle `done` pulse. It sits between a requesting datapath and the gate-level adder cells, trading latency for one adder's worth of area.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Legal range is WIDTH ≥ 2.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: request. Sampled only in IDLE or DONE.
- `a`, input, WIDTH: operand A. Captured when `start` is accepted.
- `b`, input, WIDTH: operand B. Captured when `start` is accepted.
- `cin`, input, 1: carry-in. Captured when `start` is accepted.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle pulse when the result is updated.
- `sum`, output, WIDTH: result register. Holds its value until the next completion.
- `cout`, output, 1: carry-out register. Same hold rule as `sum`.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - `start` = 1: load `a_sh`←`a`, `b_sh`←`b`, `carry`←`cin`, `cnt`←0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, on each cycle:
  - The full-adder cell computes `s` = a_sh[0]^b_sh[0]^carry and `co` = (a_sh[0]&b_sh[0]) | ((a_sh[0]^b_sh[0])&carry).
  - `s_sh` ← {s, s_sh[WIDTH-1:1]}.
  - `a_sh` and `b_sh` shift right by one, zero-filled.
  - `carry` ← `co`.
  - `cnt` ← `cnt`+1.
- RUN exit: when `cnt` == WIDTH-1, the current bit is the last one.
  - `sum` ← {s, s_sh[WIDTH-1:1]} and `cout` ← `co`.
  - Go to DONE.
- DONE:
  - `done` = 1 for exactly this cycle.
  - `start` = 1: accept a new request with the same loads as IDLE, and go directly to RUN.
  - Otherwise go to IDLE.
- `start` in RUN is ignored; it is not queued.
- Arithmetic is unsigned modulo 2^WIDTH. `cout` is bit WIDTH of a+b+cin.
- `cnt` width is $clog2(WIDTH). It never wraps inside a single operation.
- Inputs `a`, `b` and `cin` are don't-care outside the accepting cycle.

## Timing
- If `start` is accepted at edge k:
  - `busy` is high for cycles k+1 .. k+WIDTH.
  - `done` is high in cycle k+WIDTH+1.
  - New `sum`/`cout` are visible from cycle k+WIDTH+1.
- Throughput is one add per WIDTH+1 cycles when `start` is held high continuously.
- `busy` and `done` are never high together.
- During RUN, `sum` and `cout` keep the previous result with no intermediate values.
- Reset values (`rst_n` low, asynchronous, at any time including mid-RUN):
  - State = IDLE.
  - `busy` = 0, `done` = 0, `sum` = 0, `cout` = 0.
  - All shift registers, `carry` and `cnt` = 0.
  - An in-flight operation is discarded.
- After `rst_n` deasserts, the first rising edge with `start` = 1 is accepted.

## Structure
- Shared package `serial_add_pkg` holds the state encodings:
  - IDLE = 2'b00
  - RUN = 2'b01
  - DONE = 2'b10
  - Unused code 2'b11 returns to IDLE.
- The package also holds the default WIDTH constant.
- Sub-module `fa_cell` (inputs x, y, ci; outputs s, co):
  - Two `ha` instances plus an OR gate for `co`.
  - Purely combinational, instantiated once.
- The controller contains the FSM, the shift registers, `cnt`, `carry`, and the `sum`/`cout` registers.

## Test plan
- **Basic add:** WIDTH=8, `start` with a=8'h35, b=8'h4A, cin=0.
  - `busy` is high for 8 cycles.
  - `done` pulses at k+9 with `sum`=8'h7F, `cout`=0.
- **Carry ripple:** a=8'hFF, b=8'h01, cin=0 → `sum`=8'h00, `cout`=1.
- **Carry-in:** a=8'hFF, b=8'h00, cin=1 → `sum`=8'h00, `cout`=1.
- **Carry-in, no overflow:** a=8'h0F, b=8'h10, cin=1 → `sum`=8'h20, `cout`=0.
- **Ignored start and hold:** pulse `start` with new operands at k+3, mid-RUN.
  - The original result is still produced at k+9.
  - `sum` holds its prior value through cycles k+1..k+8.
- **Back-to-back:**
  - Hold `start` high with 8'h01+8'h01, then 8'h80+8'h80.
  - `done` pulses at k+9 (`sum`=8'h02, `cout`=0) and k+18 (`sum`=8'h00, `cout`=1).
  - No IDLE cycle occurs between the two operations.
- **Reset mid-op:** assert `rst_n`=0 at k+4, asynchronously between edges.
  - All outputs go to 0 immediately.
  - After release, a=8'h35+b=8'h4A completes normally 9 cycles after `start`.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared constants and FSM state encoding for the bit-serial adder.
package serial_add_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requesting datapath (master) and the
// serial adder controller (slave).
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// Gate-level adder cells: a half adder and a full adder built from two of them.
module ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p, g0, g1;

  // First stage forms propagate/generate, second folds in the carry.
  ha u_ha0 (.x(x), .y(y),  .s(p), .c(g0));
  ha u_ha1 (.x(p), .y(ci), .s(s), .c(g1));

  assign co = g0 | g1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: runs one shared full-adder cell over the
// operands LSB-first, one bit per clock, and publishes sum/cout on completion.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, s_sh_q, sum_q;
  logic [WIDTH-1:0] s_sh_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic             fa_s, fa_co;

  fa_cell u_fa (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign s_sh_d = WIDTH'({fa_s, s_sh_q} >> 1);

  // FSM, datapath shift registers and result registers in one clocked block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        // DONE accepts a new request exactly like IDLE, giving back-to-back ops.
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          s_sh_q  <= s_sh_d;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= s_sh_d;
            cout_q  <= fa_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] prev_sum;
  logic       prev_cout;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic bsy, input logic dn,
                          input logic [7:0] s, input logic co);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
    chk({tag, ".done"}, 32'(bus.done), 32'(dn));
    chk({tag, ".sum"},  32'(bus.sum),  32'(s));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(co));
  endtask

  // Issues one add, checks every RUN cycle and the completion cycle (k+9).
  // Returns positioned in the DONE cycle. ign>0 injects a mid-RUN start.
  task automatic do_add(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic [7:0] es, input logic ec,
                        input int ign, input bit hold);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb;
    bus.cin   = tc;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == ign) begin
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.cin   = 1'b1;
      end
      chk_outs({tag, ".run"}, 1'b1, 1'b0, prev_sum, prev_cout);
      @(posedge clk); #1;
      if (c == ign) bus.start = 1'b0;
    end
    chk_outs({tag, ".done"}, 1'b0, 1'b1, es, ec);
    prev_sum  = es;
    prev_cout = ec;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    prev_sum  = 8'h00;
    prev_cout = 1'b0;

    #12;
    chk_outs("reset", 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    do_add("basic",   8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 0, 1'b0);
    do_add("ripple",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    do_add("cin",     8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0, 1'b0);
    do_add("cin_nov", 8'h0F, 8'h10, 1'b1, 8'h20, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    chk_outs("idle", 1'b0, 1'b0, 8'h20, 1'b0);

    do_add("ignore",  8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3, 1'b0);
    @(posedge clk); #1;
    chk_outs("ignore.after", 1'b0, 1'b0, 8'h46, 1'b0);

    // start held high across both operations; second is accepted in DONE
    do_add("b2b1",    8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, 1'b1);
    do_add("b2b2",    8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    @(posedge clk); #1;
    chk_outs("b2b.after", 1'b0, 1'b0, 8'h00, 1'b1);

    // Reset asserted between edges in cycle k+4 of an operation
    do_add("prerst",  8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    bus.cin   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk_outs("midrun", 1'b1, 1'b0, 8'h7F, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n     = 1'b1;
    prev_sum  = 8'h00;
    prev_cout = 1'b0;
    do_add("postrst", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    chk_outs("postrst.after", 1'b0, 1'b0, 8'h7F, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
